// File: rtl/dda_pkg.sv
// Shared constants and types for the DDA SPI command front-end.
package dda_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WR_MU  = 8'h01;
    localparam logic [7:0] OP_WR_ICX = 8'h02;
    localparam logic [7:0] OP_WR_ICY = 8'h03;
    localparam logic [7:0] OP_LOAD   = 8'h04;
    localparam logic [7:0] OP_STEP   = 8'h05;

    // Posit reset values: mu = 1.0, initial conditions = 0.5
    localparam logic [15:0] MU_RST = 16'h4000;
    localparam logic [15:0] IC_RST = 16'h3000;

    localparam int FRAME_BITS = 32;
    localparam logic [5:0] BITCNT_SAT = 6'd33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } step_state_e;

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronizes the pins into clk, collects 32-bit
// command frames and shifts the {x, y} snapshot back out on MISO.
module spi_frame_rx
    import dda_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk_i,
    input  logic         cs_n_i,
    input  logic         mosi_i,
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic         miso_o,
    output logic         frame_vld_o,
    output logic [7:0]   opcode_o,
    output logic [7:0]   arg_o,
    output logic [15:0]  data_o
);

    logic [2:0]     sck_q;
    logic [2:0]     csn_q;
    logic [1:0]     mosi_q;
    logic [5:0]     bitcnt_q;
    logic [31:0]    rx_q;
    logic [2*N-1:0] tx_q;

    logic sck_rise, sck_fall, cs_fall, cs_rise, cs_act;

    // Bit 0 is the metastability flop; edges compare the two settled taps.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~csn_q[1] & csn_q[2];
    assign cs_rise  = csn_q[1] & ~csn_q[2];
    assign cs_act   = ~csn_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_q    <= 3'b000;
            csn_q    <= 3'b111;
            mosi_q   <= 2'b00;
            bitcnt_q <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sclk_i};
            csn_q  <= {csn_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
            if (cs_fall) begin
                bitcnt_q <= '0;
                tx_q     <= {x_i, y_i};
            end else if (cs_act) begin
                if (sck_rise) begin
                    rx_q <= {rx_q[30:0], mosi_q[1]};
                    if (bitcnt_q != BITCNT_SAT)
                        bitcnt_q <= bitcnt_q + 6'd1;
                end
                if (sck_fall)
                    tx_q <= {tx_q[2*N-2:0], 1'b0};
            end
        end
    end

    // Only an exact-length frame commits; short or long frames vanish.
    assign frame_vld_o = cs_rise && (bitcnt_q == 6'(FRAME_BITS));
    assign opcode_o    = rx_q[31:24];
    assign arg_o       = rx_q[23:16];
    assign data_o      = rx_q[15:0];
    assign miso_o      = tx_q[2*N-1];

endmodule

// File: rtl/dda_spi_ctrl.sv
// SPI command front-end for the Van der Pol DDA: parameter registers,
// load strobe and a step sequencer that spaces dda_step pulses.
module dda_spi_ctrl
    import dda_pkg::*;
#(
    parameter int N        = 16,
    parameter int STEP_GAP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic [N-1:0] mu,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic         dda_load,
    output logic         dda_step,
    output logic         busy
);

    localparam int GW = $clog2(STEP_GAP + 1);

    logic        frame_vld;
    logic [7:0]  opcode, arg;
    logic [15:0] data;

    spi_frame_rx #(.N(N)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .x_i        (x_in),
        .y_i        (y_in),
        .miso_o     (miso),
        .frame_vld_o(frame_vld),
        .opcode_o   (opcode),
        .arg_o      (arg),
        .data_o     (data)
    );

    logic        cmd_load, cmd_step;
    step_state_e state_q, state_d;
    logic [8:0]  rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [N-1:0] mu_q, icx_q, icy_q;
    logic        load_q;

    assign cmd_load = frame_vld && (opcode == OP_LOAD);
    assign cmd_step = frame_vld && (opcode == OP_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mu_q   <= N'(MU_RST);
            icx_q  <= N'(IC_RST);
            icy_q  <= N'(IC_RST);
            load_q <= 1'b0;
        end else begin
            load_q <= cmd_load;
            if (frame_vld) begin
                case (opcode)
                    OP_WR_MU:  mu_q  <= N'(data);
                    OP_WR_ICX: icx_q <= N'(data);
                    OP_WR_ICY: icy_q <= N'(data);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_step) begin
                    state_d = ST_PULSE;
                    rem_d   = {1'b0, arg} + 9'd1;
                end
            end
            ST_PULSE: begin
                rem_d   = rem_q - 9'd1;
                gap_d   = GW'(STEP_GAP - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0)
                    state_d = (rem_q != 9'd0) ? ST_PULSE : ST_IDLE;
                else
                    gap_d = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // LOAD re-seeds the integrator, so any burst in flight is dropped.
        if (cmd_load)
            state_d = ST_IDLE;
    end

    assign mu       = mu_q;
    assign icx      = icx_q;
    assign icy      = icy_q;
    assign dda_load = load_q;
    assign dda_step = (state_q == ST_PULSE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dda_spi_ctrl.sv
// Directed bench for dda_spi_ctrl: SPI frames in, parameter/strobe/readback checks.
module tb_dda_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [15:0] mu, icx, icy;
    logic        dda_load, dda_step, busy;

    int n_chk = 0;
    int n_pass = 0;

    // Strobe monitor state, cleared through clr
    logic clr = 1'b0;
    int   cyc = 0;
    int   last_step = 0;
    int   step_cnt = 0;
    int   load_cnt = 0;
    int   busy_cyc = 0;
    int   per_bad = 0;

    logic [32:0] rx;
    int          snap;

    dda_spi_ctrl #(.N(16), .STEP_GAP(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .x_in    (x_in),
        .y_in    (y_in),
        .mu      (mu),
        .icx     (icx),
        .icy     (icy),
        .dda_load(dda_load),
        .dda_step(dda_step),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            step_cnt <= 0;
            load_cnt <= 0;
            busy_cyc <= 0;
            per_bad  <= 0;
        end else begin
            if (dda_step) begin
                if (step_cnt != 0 && (cyc - last_step) != 5)
                    per_bad <= per_bad + 1;
                last_step <= cyc;
                step_cnt  <= step_cnt + 1;
            end
            if (dda_load) load_cnt <= load_cnt + 1;
            if (busy)     busy_cyc <= busy_cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Mode-0 master, MSB first; sends tx[nbits-1:0], returns MISO bits in rx.
    // Half periods and cs_n setup are 4 clk each. Returns on the cs_n rise negedge.
    task automatic spi_xfer(input logic [32:0] tx, input int nbits, output logic [32:0] rxo);
        rxo = '0;
        cycles(6);
        cs_n = 1'b0;
        cycles(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = tx[i];
            cycles(4);
            rxo  = {rxo[31:0], miso};
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        cycles(4);
        cs_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    initial begin
        do_reset();
        chk("rst_mu", mu, 64'h4000);
        chk("rst_icx", icx, 64'h3000);
        chk("rst_icy", icy, 64'h3000);
        chk("rst_busy", busy, 0);
        chk("rst_miso", miso, 0);
        chk("rst_load", dda_load, 0);
        chk("rst_step", dda_step, 0);
        clear_mon();
        cycles(100);
        chk("idle_steps", step_cnt, 0);
        chk("idle_loads", load_cnt, 0);
        chk("idle_busy", busy_cyc, 0);

        // mu write with readback of the snapshot; commit lands on edge k+2
        x_in = 16'hABCD; y_in = 16'h1234;
        spi_xfer({1'b0, 32'h0100_3800}, 32, rx);
        chk("rdbk32", rx[31:0], 64'hABCD_1234);
        cycles(2);
        chk("mu_k1", mu, 64'h4000);
        cycles(1);
        chk("mu_k2", mu, 64'h3800);
        chk("icx_keep", icx, 64'h3000);
        chk("icy_keep", icy, 64'h3000);

        // Short and long frames must be discarded
        spi_xfer({2'b00, 31'h0100_091A}, 31, rx);
        cycles(5);
        chk("trunc31_icx", icx, 64'h3000);
        spi_xfer({32'h0200_1234, 1'b0}, 33, rx);
        cycles(5);
        chk("long33_icx", icx, 64'h3000);
        chk("rdbk33", rx, {31'h0, 32'hABCD_1234, 1'b0});

        spi_xfer({1'b0, 32'h0200_1234}, 32, rx);
        cycles(5);
        chk("icx_wr", icx, 64'h1234);
        spi_xfer({1'b0, 32'h0300_5678}, 32, rx);
        cycles(5);
        chk("icy_wr", icy, 64'h5678);
        chk("mu_hold", mu, 64'h3800);
        spi_xfer({1'b0, 32'h0700_1111}, 32, rx);
        cycles(5);
        chk("unk_op_mu", mu, 64'h3800);

        // STEP arg=3: 4 pulses, 5 cycles apart, 20 busy cycles
        clear_mon();
        spi_xfer({1'b0, 32'h0503_0000}, 32, rx);
        cycles(2);
        chk("step_k1_busy", busy, 0);
        chk("step_k1_step", dda_step, 0);
        cycles(1);
        chk("step_k2_step", dda_step, 1);
        chk("step_k2_busy", busy, 1);
        cycles(40);
        chk("step4_cnt", step_cnt, 4);
        chk("step4_busy", busy_cyc, 20);
        chk("step4_period", per_bad, 0);
        chk("step4_noload", load_cnt, 0);

        // STEP arg=0x40 (65 pulses); a second STEP during the burst is ignored
        clear_mon();
        spi_xfer({1'b0, 32'h0540_0000}, 32, rx);
        spi_xfer({1'b0, 32'h0503_0000}, 32, rx);
        cycles(3);
        chk("step65_busy_mid", busy, 1);
        cycles(200);
        chk("step65_cnt", step_cnt, 65);
        chk("step65_busy", busy_cyc, 325);
        chk("step65_period", per_bad, 0);

        // LOAD during a long burst aborts it on the same edge
        clear_mon();
        spi_xfer({1'b0, 32'h05FF_0000}, 32, rx);
        spi_xfer({1'b0, 32'h0400_0000}, 32, rx);
        cycles(2);
        chk("load_k1_busy", busy, 1);
        chk("load_k1_load", dda_load, 0);
        cycles(1);
        chk("load_k2_load", dda_load, 1);
        chk("load_k2_busy", busy, 0);
        chk("load_k2_step", dda_step, 0);
        snap = step_cnt;
        chk("load_had_steps", (snap > 40) ? 1 : 0, 1);
        cycles(100);
        chk("load_no_more_steps", step_cnt, snap);
        chk("load_once", load_cnt, 1);

        // Reset in the middle of a burst
        spi_xfer({1'b0, 32'h05FF_0000}, 32, rx);
        cycles(30);
        do_reset();
        chk("mrst_mu", mu, 64'h4000);
        chk("mrst_icx", icx, 64'h3000);
        chk("mrst_busy", busy, 0);
        clear_mon();
        cycles(100);
        chk("mrst_steps", step_cnt, 0);
        chk("mrst_loads", load_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
